// File: rtl/axi4_lite_led_cnt_slave.sv
// AXI4-Lite register slave (CTRL/PERIOD/COUNT/SCRATCH) driving a prescaled LED counter.
// Latency: write commits one cycle after AW and W are both held, BVALID the cycle after; read data one cycle after AR.
// Backpressure: AW/W stall while a B response is pending; AR stalls while an R response is pending.
module axi4_lite_led_cnt_slave #(
  parameter int                              C_S_AXI_DATA_WIDTH = 32,
  parameter int                              C_S_AXI_ADDR_WIDTH = 4,
  parameter int                              LED_WIDTH          = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]   DEFAULT_PERIOD     = 32'd49_999_999
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]              LED
);

  localparam int              DW  = C_S_AXI_DATA_WIDTH;
  localparam int              SW  = DW / 8;
  localparam logic [DW-1:0]   ONE = 1;

  // write holding state
  logic          aw_held, w_held;
  logic [1:0]    aw_sel;
  logic [DW-1:0] w_dat;
  logic [SW-1:0] w_strb;
  logic          b_vld;

  // read response state
  logic          r_vld;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] rd_mux;

  // register file and counter
  logic          ctrl_en;
  logic [DW-1:0] period_q, scratch_q, count_q, presc_q;
  logic [DW-1:0] count_nxt, presc_nxt;
  logic [LED_WIDTH-1:0] led_q;

  logic aw_hs, w_hs, ar_hs, wr_commit, clr_pulse;

  // Protection bits and the byte-offset/upper address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Ready signals are held low during reset so nothing handshakes while the block is cleared.
  assign S_AXI_AWREADY = !ARESET && !aw_held && !b_vld;
  assign S_AXI_WREADY  = !ARESET && !w_held && !b_vld;
  assign S_AXI_ARREADY = !ARESET && !r_vld;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RDATA   = r_dat;
  assign S_AXI_RRESP   = 2'b00;
  assign LED           = led_q;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_commit = aw_held && w_held;
  assign clr_pulse = wr_commit && (aw_sel == 2'd0) && w_strb[0] && w_dat[1];

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Hold AW and W independently; once both are present, commit and raise the B response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      b_vld   <= 1'b0;
      aw_sel  <= 2'd0;
      w_dat   <= '0;
      w_strb  <= '0;
    end else if (wr_commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      b_vld   <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_sel  <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_dat  <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (b_vld && S_AXI_BREADY) b_vld <= 1'b0;
    end
  end

  // Apply the committed write to the writable registers; COUNT writes are dropped.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_en   <= 1'b0;
      period_q  <= DEFAULT_PERIOD;
      scratch_q <= '0;
    end else if (wr_commit) begin
      case (aw_sel)
        2'd0:    if (w_strb[0]) ctrl_en <= w_dat[0];
        2'd1:    period_q  <= merge_bytes(period_q, w_dat, w_strb);
        2'd3:    scratch_q <= merge_bytes(scratch_q, w_dat, w_strb);
        default: ;
      endcase
    end
  end

  // Prescaler/counter next state; CLR wins over a tick landing on the same edge.
  always_comb begin
    presc_nxt = presc_q;
    count_nxt = count_q;
    if (clr_pulse) begin
      presc_nxt = '0;
      count_nxt = '0;
    end else if (ctrl_en) begin
      if (presc_q == period_q) begin
        presc_nxt = '0;
        count_nxt = count_q + ONE;
      end else begin
        presc_nxt = presc_q + ONE;
      end
    end
  end

  // Counter registers; LED loads from the same next value so it never lags COUNT.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      presc_q <= '0;
      count_q <= '0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_nxt;
      count_q <= count_nxt;
      led_q   <= count_nxt[LED_WIDTH-1:0];
    end
  end

  // Read mux over current register values, so a same-edge write is not yet visible.
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = {{(DW-1){1'b0}}, ctrl_en};
      2'd1:    rd_mux = period_q;
      2'd2:    rd_mux = count_q;
      default: rd_mux = scratch_q;
    endcase
  end

  // Capture read data at the AR handshake and hold it until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (ar_hs) begin
      r_vld <= 1'b1;
      r_dat <= rd_mux;
    end else if (r_vld && S_AXI_RREADY) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_led_cnt_slave.sv
// Directed bench for the CNT_LED AXI4-Lite slave.
// Inputs are driven and outputs sampled on the falling clock edge.
// Register accesses come from a vector table; channel corner cases are hand-written sequences.
module tb_axi4_lite_led_cnt_slave;

  localparam logic [31:0] DEF_PERIOD = 32'd49_999_999;

  logic        aclk;
  logic        arst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [3:0]  led;

  int tests = 0;
  int fails = 0;
  int b_cnt = 0;

  axi4_lite_led_cnt_slave dut (
    .ACLK          (aclk),
    .ARESET        (arst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .LED           (led)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // count every B handshake the DUT completes
  always @(posedge aclk) begin
    if (bvalid && bready) b_cnt <= b_cnt + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    tests++;
    if ($isunknown(act) || act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected range 0x%08h..0x%08h", name, act, lo, hi);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge aclk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (bvalid) resp = bresp;
    else        resp = 2'b11;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!arready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    while (!rvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (rvalid) begin data = rdata; resp = rresp; end
    else        begin data = 'x;    resp = 2'b11; end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          b0;
  bit          hold_ok;

  initial begin
    arst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    // register access table: {is_wr, addr, wdata, wstrb, expected read}
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 4'h4, 32'h0,        4'h0, 32'h02FAF07F});
    vecs.push_back('{1'b0, 4'h8, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 4'hC, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 4'hC, 32'hDEADBEEF, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'hC, 32'h00005500, 4'h2, 32'h0});
    vecs.push_back('{1'b0, 4'hC, 32'h0,        4'h0, 32'hDEAD55EF});
    vecs.push_back('{1'b1, 4'h8, 32'h00001234, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h8, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 4'hC, 32'h11223344, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 4'hC, 32'h0,        4'h0, 32'hDEAD55EF});
    vecs.push_back('{1'b1, 4'h4, 32'hAABBCCDD, 4'h9, 32'h0});
    vecs.push_back('{1'b0, 4'h4, 32'h0,        4'h0, 32'hAAFAF0DD});
    vecs.push_back('{1'b1, 4'h0, 32'hFFFFFFFC, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h00000001, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h1});
    vecs.push_back('{1'b1, 4'h0, 32'h00000002, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0,        4'h0, 32'h0});
    vecs.push_back('{1'b0, 4'h8, 32'h0,        4'h0, 32'h0});

    // reset state
    repeat (3) @(negedge aclk);
    check_bit("rst_awready", awready, 1'b0);
    check_bit("rst_wready",  wready,  1'b0);
    check_bit("rst_arready", arready, 1'b0);
    check_bit("rst_bvalid",  bvalid,  1'b0);
    check_bit("rst_rvalid",  rvalid,  1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {28'h0, led}, 32'h0);
    arst = 1'b0;
    @(negedge aclk);
    check_bit("idle_awready", awready, 1'b1);
    check_bit("idle_arready", arready, 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
        check($sformatf("vec%0d_bresp", i), {30'h0, rsp}, 32'h0);
      end else begin
        axi_read(vecs[i].addr, rd, rsp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        check($sformatf("vec%0d_rresp", i), {30'h0, rsp}, 32'h0);
      end
    end

    // PERIOD=3: one COUNT tick per 4 enabled cycles; 40 edges after the CTRL commit -> 10
    axi_write(4'h4, 32'd3, 4'hF, rsp);
    axi_write(4'h0, 32'd1, 4'hF, rsp);
    repeat (39) @(negedge aclk);
    check("led_after_40", {28'h0, led}, 32'hA);
    axi_read(4'h8, rd, rsp);
    check_range("count_after_40", rd, 32'd9, 32'd11);

    // AW five cycles ahead of W, B held off for four cycles
    b0 = b_cnt;
    hold_ok = 1;
    @(negedge aclk);
    awaddr = 4'hC; awvalid = 1'b1; bready = 1'b0;
    @(negedge aclk);
    awvalid = 1'b0;
    repeat (4) begin
      if (awready !== 1'b0 || bvalid !== 1'b0) hold_ok = 0;
      @(negedge aclk);
    end
    check_bit("aw_only_hold", hold_ok, 1'b1);
    check_bit("aw_held_awready", awready, 1'b0);
    check_bit("aw_held_wready", wready, 1'b1);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    check_bit("w_hs_plus1_bvalid", bvalid, 1'b0);
    check_bit("w_hs_plus1_wready", wready, 1'b0);
    @(negedge aclk);
    check_bit("w_hs_plus2_bvalid", bvalid, 1'b1);
    hold_ok = 1;
    repeat (4) begin
      @(negedge aclk);
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) hold_ok = 0;
    end
    check_bit("b_backpressure_hold", hold_ok, 1'b1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check_bit("b_done_bvalid", bvalid, 1'b0);
    check_bit("b_done_awready", awready, 1'b1);
    check_bit("b_done_wready", wready, 1'b1);
    repeat (3) @(negedge aclk);
    check("b_single_resp", b_cnt, b0 + 1);
    axi_read(4'hC, rd, rsp);
    check("split_write_data", rd, 32'hCAFEF00D);

    // PERIOD=0 full-rate counting, then CLR with and without EN
    axi_write(4'h0, 32'h2, 4'hF, rsp);
    axi_write(4'h4, 32'h0, 4'hF, rsp);
    axi_write(4'h0, 32'h1, 4'hF, rsp);
    repeat (5) @(negedge aclk);
    axi_read(4'h8, rd, rsp);
    check_range("p0_running", rd, 32'd5, 32'd20);
    axi_write(4'h0, 32'h3, 4'hF, rsp);
    axi_read(4'h8, rd, rsp);
    check_range("clr_en_small", rd, 32'd0, 32'd8);
    axi_read(4'h0, rd, rsp);
    check("clr_en_ctrl", rd, 32'h1);
    axi_write(4'h0, 32'h2, 4'hF, rsp);
    axi_read(4'h8, rd, rsp);
    check("clr_stop_count", rd, 32'h0);
    repeat (20) @(negedge aclk);
    axi_read(4'h8, rd, rsp);
    check("clr_stop_count_later", rd, 32'h0);
    check("clr_stop_led", {28'h0, led}, 32'h0);

    // reset with a held AW and an unaccepted R response
    @(negedge aclk);
    awaddr = 4'hC; awvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    arvalid = 1'b0;
    check_bit("pre_rst_rvalid", rvalid, 1'b1);
    arst = 1'b1;
    @(negedge aclk);
    check_bit("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rdata", rdata, 32'h0);
    check_bit("mid_rst_arready", arready, 1'b0);
    arst = 1'b0;
    @(negedge aclk);
    check_bit("post_rst_arready", arready, 1'b1);
    check_bit("post_rst_awready", awready, 1'b1);
    b0 = b_cnt;
    // lone W: would complete a write if the pre-reset AW had survived
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    repeat (4) @(negedge aclk);
    check_bit("dropped_aw_no_bvalid", bvalid, 1'b0);
    check("dropped_aw_no_resp", b_cnt, b0);
    bready = 1'b0;
    arst = 1'b1;
    @(negedge aclk);
    arst = 1'b0;
    axi_read(4'h4, rd, rsp);
    check("post_rst_period", rd, DEF_PERIOD);
    axi_read(4'hC, rd, rsp);
    check("post_rst_scratch", rd, 32'h0);
    axi_read(4'h8, rd, rsp);
    check("post_rst_count", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_led_cnt_slave.md
Name: axi4_lite_led_cnt_slave

Overview:
AXI4-Lite slave (responder) for the CNT_LED peripheral. It accepts the single-beat write and read transfers issued by a Microblaze or VIP master. It exposes four 32-bit registers: control, period, count (read-only) and scratch. It drives a free-running LED counter whose tick rate is set by a programmable prescaler.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
LED_WIDTH, 4, number of LED outputs; 1..32.
DEFAULT_PERIOD, 32'd49_999_999, reset value of the PERIOD register.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  reset; synchronous, active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  always 2'b00 (OKAY).
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 2'b00.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
LED  out  LED_WIDTH  COUNT[LED_WIDTH-1:0].

Behaviour:
- Reset (ARESET=1 at a clock edge) forces: all READY/VALID outputs = 0, RDATA = 0, CTRL = 0, COUNT = 0, prescaler = 0, SCRATCH = 0, PERIOD = DEFAULT_PERIOD.
- Reset mid-transaction drops any held AW/W and any pending B/R. No response is issued for the dropped transfer.
- Register map, decoded from ADDR[3:2]:
  - 0 CTRL: bit0 EN (R/W); bit1 CLR (write-1 pulse, reads 0); other bits read 0.
  - 1 PERIOD (R/W).
  - 2 COUNT (RO; writes are ignored but still answered OKAY).
  - 3 SCRATCH (R/W).
- Write channel:
  - Two independent holding flags, aw_held and w_held.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - A handshake sets the matching flag and captures address or data+strobe.
  - In the cycle where both flags are set: the register update commits at that edge, both flags clear, BVALID rises.
  - AW and W accepted together in cycle T: flags set at T+1, BVALID=1 in cycle T+2.
  - AW and W may arrive in either order, any cycles apart.
  - BVALID holds until BREADY=1, then deasserts the next cycle. No new AW/W is accepted while BVALID=1.
  - Writes honour WSTRB per byte; WSTRB=0 changes nothing but still responds.
- Read channel:
  - ARREADY = !RVALID.
  - An AR handshake in cycle T gives RVALID=1 with RDATA stable in cycle T+1.
  - RVALID and RDATA hold until RREADY=1; ARREADY returns the cycle after.
  - COUNT is sampled at the AR handshake edge.
- Reads and writes are fully independent. A simultaneous read and write of the same register returns the pre-write value.
- Counter:
  - While EN=1, the prescaler increments every cycle.
  - When prescaler == PERIOD: prescaler goes to 0 and COUNT increments, wrapping 0xFFFFFFFF → 0.
  - PERIOD=0 gives one COUNT increment per cycle.
  - EN=0 freezes both the prescaler and COUNT.
  - If PERIOD is written below the current prescaler value, the prescaler counts up and wraps at 2^32 before matching; no special handling.
  - CLR written 1 zeroes the prescaler and COUNT at the commit edge. CLR takes priority over a tick at the same edge. EN takes the bit0 value from the same write.
- LED is registered from COUNT, zero latency relative to COUNT.

Test Plan:
- Reset, then read all four registers → CTRL=0, PERIOD=DEFAULT_PERIOD, COUNT=0, SCRATCH=0, all RRESP=00.
- Write SCRATCH=0xDEADBEEF, then write with WSTRB=4'b0010 data 0x00005500, then read → 0xDEAD55EF. Also write COUNT=0x1234 with EN=0 and read → 0.
- PERIOD=3, CTRL=1, wait 40 cycles after the commit edge → COUNT=10 (±1 depending on read-sample edge), LED=4'hA.
- AW presented 5 cycles before W, with BREADY held low 4 cycles after BVALID:
  - BVALID rises 2 cycles after the W handshake.
  - AWREADY and WREADY stay 0 until the B handshake.
  - Exactly one B response is issued.
- Counter running with PERIOD=0; write CTRL=0x3 → COUNT reads 0 or a small value. Then write CTRL=0x2 → COUNT stays 0 indefinitely.
- Assert ARESET while RVALID=1 with RREADY=0 → RVALID=0 the next cycle; a subsequent read of PERIOD returns DEFAULT_PERIOD.
